// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode, execute,
// memory and writeback, and drives every datapath select and write enable.
module mips_multicycle_ctrl #(
    parameter logic [5:0] OPC_RTYPE = 6'b000000,
    parameter logic [5:0] OPC_LW    = 6'b100011,
    parameter logic [5:0] OPC_SW    = 6'b101011,
    parameter logic [5:0] OPC_BEQ   = 6'b000100,
    parameter logic [5:0] OPC_J     = 6'b000010,
    parameter logic [5:0] OPC_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11
    } state_e;

    state_e state_q, state_d;
    logic   pc_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:   state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (opcode)
                    OPC_LW, OPC_SW: state_d = StMemAddr;
                    OPC_RTYPE:      state_d = StExec;
                    OPC_BEQ:        state_d = StBranch;
                    OPC_J:          state_d = StJump;
                    OPC_ADDI:       state_d = StAddiEx;
                    default:        state_d = StFetch;
                endcase
            end
            // IR holds the opcode, so it still distinguishes LW from SW here.
            StMemAddr: state_d = (opcode == OPC_SW) ? StMemWr : StMemRd;
            StMemRd:   state_d = mem_ready ? StMemWb : StMemRd;
            StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
            StExec:    state_d = StRWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        // Reset overrides everything combinationally so strobes drop mid-instruction.
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StDecode: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !(opcode inside {OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_J,
                                                  OPC_ADDI});
                end
                StMemAddr, StAddiEx: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                StExec: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                StRWb: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                StBranch: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_source     = 2'b01;
                    pc_write_cond = 1'b1;
                end
                StJump: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                end
                StAddiWb:  reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign state_o = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class cycle by cycle and
// compares the full control word against hand-written per-state vectors.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;
    logic [20:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .pc_write_cond(pc_write_cond),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .illegal_op   (illegal_op),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Flag order: pc_en pc_write_cond i_or_d mem_read mem_write ir_write mem_to_reg
    // reg_dst reg_write alu_src_a, then alu_src_b, alu_op, pc_source, illegal_op, state.
    assign outs = {pc_en, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
                   state_o};

    localparam logic [20:0] E_RST    = 21'd0;
    localparam logic [20:0] E_FETCH  = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0, 4'd0};
    localparam logic [20:0] E_FETCHW = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0, 4'd0};
    localparam logic [20:0] E_DEC    = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0, 4'd1};
    localparam logic [20:0] E_DECILL = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1, 4'd1};
    localparam logic [20:0] E_MADDR  = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 4'd2};
    localparam logic [20:0] E_MRD    = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 4'd3};
    localparam logic [20:0] E_MWB    = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0, 4'd4};
    localparam logic [20:0] E_MWR    = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, 4'd5};
    localparam logic [20:0] E_EXEC   = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0, 4'd6};
    localparam logic [20:0] E_RWB    = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0, 4'd7};
    localparam logic [20:0] E_BR1    = {10'b1100000001, 2'b00, 2'b01, 2'b01, 1'b0, 4'd8};
    localparam logic [20:0] E_BR0    = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0, 4'd8};
    localparam logic [20:0] E_JMP    = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0, 4'd9};
    localparam logic [20:0] E_AEX    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 4'd10};
    localparam logic [20:0] E_AWB    = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0, 4'd11};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock, apply mem_ready for the new cycle, then compare the control word.
    task automatic cyc(input logic mr, input string tag, input logic [20:0] exp);
        @(posedge clk);
        #1;
        mem_ready = mr;
        #1;
        check(tag, outs, exp);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("reset_outs", outs, E_RST);
        reset = 1'b0;
        #1;
        check("rt_fetch", outs, E_FETCH);

        // R-type: 0,1,6,7,0
        cyc(1'b1, "rt_decode", E_DEC);
        cyc(1'b1, "rt_exec",   E_EXEC);
        cyc(1'b1, "rt_wb",     E_RWB);
        cyc(1'b1, "rt_fetch2", E_FETCH);

        // LW with two wait cycles in MEM_RD: 0,1,2,3,3,3,4,0
        opcode = 6'b100011;
        cyc(1'b1, "lw_decode", E_DEC);
        cyc(1'b1, "lw_addr",   E_MADDR);
        cyc(1'b0, "lw_rd1",    E_MRD);
        cyc(1'b0, "lw_rd2",    E_MRD);
        cyc(1'b1, "lw_rd3",    E_MRD);
        cyc(1'b1, "lw_wb",     E_MWB);
        cyc(1'b1, "lw_fetch",  E_FETCH);

        // Fetch stall: PC/IR load only in the cycle mem_ready is seen
        opcode = 6'b000100;
        zero   = 1'b1;
        cyc(1'b1, "beq_decode", E_DEC);
        cyc(1'b1, "beq_taken",  E_BR1);
        cyc(1'b0, "fetch_wait", E_FETCHW);
        cyc(1'b1, "fetch_go",   E_FETCH);
        zero = 1'b0;
        cyc(1'b1, "beq_decode2", E_DEC);
        cyc(1'b1, "beq_nottkn",  E_BR0);
        cyc(1'b1, "beq_fetch",   E_FETCH);

        // Jump
        opcode = 6'b000010;
        cyc(1'b1, "j_decode", E_DEC);
        cyc(1'b1, "j_jump",   E_JMP);
        cyc(1'b1, "j_fetch",  E_FETCH);

        // ADDI: 0,1,10,11,0
        opcode = 6'b001000;
        cyc(1'b1, "addi_decode", E_DEC);
        cyc(1'b1, "addi_ex",     E_AEX);
        cyc(1'b1, "addi_wb",     E_AWB);
        cyc(1'b1, "addi_fetch",  E_FETCH);

        // Illegal opcode: single-cycle pulse, straight back to fetch
        opcode = 6'b111111;
        cyc(1'b1, "ill_decode", E_DECILL);
        cyc(1'b1, "ill_fetch",  E_FETCH);

        // SW stalled in MEM_WR, then reset asserted mid-access
        opcode = 6'b101011;
        cyc(1'b1, "sw_decode", E_DEC);
        cyc(1'b1, "sw_addr",   E_MADDR);
        cyc(1'b0, "sw_wr1",    E_MWR);
        cyc(1'b0, "sw_wr2",    E_MWR);
        reset = 1'b1;
        #1;
        check("sw_reset_now", outs, E_RST);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("sw_resume_fetch", outs, E_FETCH);
        cyc(1'b1, "sw_resume_dec", E_DEC);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
